// File: rtl/bus_req_seq.sv
// Request sequencer: buffers core read/write requests and drives the bus ALE -> CMD -> WAIT handshake.
// Define BUS_TIMEOUT_EN to bound WAIT to TIMEOUT stalled cycles, ending with an error response.
module bus_req_seq #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          bus_ready,
  output logic                          ale_en,
  output logic                          bus_read_en,
  output logic                          bus_write_en,
  output logic [ADDR_W-1:0]             addr_input,
  output logic [DATA_W-1:0]             data_write,
  input  logic [DATA_W-1:0]             data_read
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("bus_req_seq: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ALE  = 3'd1,
    CMD  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  cmd_t              cur_q, cur_d;
  logic              push, pop;
  logic              ale_q, ale_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d, rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign req_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0) && bus_ready;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    rdata_d  = rdata_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
`ifdef BUS_TIMEOUT_EN
    err_d    = err_q;
    tmo_d    = '0;
    if (state_q == WAIT && !bus_ready) tmo_d = tmo_q + TMO_W'(1);
`endif
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ALE;
          cur_d   = fifo_q[rd_ptr_q];
        end
      end
      ALE:  state_d = CMD;
      CMD:  state_d = WAIT;
      WAIT: begin
        if (bus_ready) begin
          state_d = RESP;
          rdata_d = cur_q.write ? '0 : data_read;
`ifdef BUS_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs take the value belonging to the state being entered.
    ale_d       = (state_d == ALE);
    rd_en_d     = (state_d == ALE || state_d == CMD) && !cur_d.write;
    wr_en_d     = (state_d == ALE || state_d == CMD) &&  cur_d.write;
    rsp_valid_d = (state_d == RESP);
    if (state_d == ALE) begin
      addr_d = cur_d.addr;
      wdat_d = cur_d.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_q       <= '0;
      ale_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_q       <= cur_d;
      ale_q       <= ale_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  // Command storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
    end
  end

  assign ale_en       = ale_q;
  assign bus_read_en  = rd_en_q;
  assign bus_write_en = wr_en_q;
  assign addr_input   = addr_q;
  assign data_write   = wdat_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign fifo_count   = count_q;
`ifdef BUS_TIMEOUT_EN
  assign rsp_err      = err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_req_seq.sv
// Bench for bus_req_seq: behavioural bus memory, in-order response scoreboard, randomized traffic.
module tb_bus_req_seq;
  localparam int unsigned ADDR_W = 8, DATA_W = 8, FIFO_DEPTH = 4, TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic [2:0] fifo_count;
  logic       bus_ready, ale_en, bus_read_en, bus_write_en;
  logic [7:0] addr_input, data_write, data_read;

  int         n_cmp = 0, n_bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] model_mem [256];
  bit         last_acc;
  bit         ale_prev = 1'b0;
  int         both_cnt = 0, ale_dbl = 0;
  int         bus_lat = 2;
  bit         bus_stall = 1'b0;
  logic [7:0] bus_mem [256];
  int         bus_timer;

  always #5 clk = ~clk;

  bus_req_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fifo_count(fifo_count),
    .bus_ready(bus_ready), .ale_en(ale_en), .bus_read_en(bus_read_en), .bus_write_en(bus_write_en),
    .addr_input(addr_input), .data_write(data_write), .data_read(data_read)
  );

  // Bus: an ALE cycle executes the access; bus_ready returns bus_lat cycles later unless stalled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_ready <= 1'b1;
      bus_timer <= 0;
      data_read <= '0;
      for (int i = 0; i < 256; i++) bus_mem[i] <= '0;
    end else if (ale_en) begin
      bus_ready <= 1'b0;
      bus_timer <= bus_lat;
      if (bus_write_en) bus_mem[addr_input] <= data_write;
      else              data_read <= bus_mem[addr_input];
    end else if (!bus_ready && !bus_stall) begin
      if (bus_timer <= 1) bus_ready <= 1'b1;
      else                bus_timer <= bus_timer - 1;
    end
  end

  // One clock: log handshakes that the coming edge will take, then observe after it.
  task automatic tick();
    #1;
    last_acc = rst && req_valid && req_ready;
    if (last_acc) begin
      if (req_write) begin
        model_mem[req_addr] = req_wdata;
        exp_q.push_back({1'b0, 8'h00});
      end else begin
        exp_q.push_back({1'b0, model_mem[req_addr]});
      end
    end
    if (rst && rsp_valid && rsp_ready) got_q.push_back({rsp_err, rsp_rdata});
    @(negedge clk);
    if (bus_read_en && bus_write_en) both_cnt++;
    if (ale_en && ale_prev) ale_dbl++;
    ale_prev = ale_en;
  endtask

  task automatic push_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int budget, output bit ok);
    ok = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = last_acc;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) tick();
  endtask

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    n_cmp++; if ({ale_en, bus_read_en, bus_write_en} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {ale_en, bus_read_en, bus_write_en}); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== 10'h000) begin n_bad++; $display("FAIL reset_rsp: got %h want 000", {rsp_valid, rsp_err, rsp_rdata}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if ({addr_input, data_write} !== 16'h0000) begin n_bad++; $display("FAIL reset_busout: got %h want 0000", {addr_input, data_write}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int ale_n = 0, wr_n = 0, rd_n = 0, ale_t = -1, first_rsp = -1;
    logic [7:0] ale_addr = '0, ale_data = '0;
    logic [8:0] rsp_word = '0, e, g;
    bus_lat = 2; rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (last_acc !== 1'b1) begin n_bad++; $display("FAIL sw_accept: got %b want 1", last_acc); end
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (ale_en) begin ale_n++; ale_t = t; ale_addr = addr_input; ale_data = data_write; end
      if (bus_write_en) wr_n++;
      if (bus_read_en) rd_n++;
      if (rsp_valid && first_rsp < 0) begin first_rsp = t; rsp_word = {rsp_err, rsp_rdata}; end
    end
    n_cmp++; if (ale_n != 1) begin n_bad++; $display("FAIL sw_ale_cycles: got %0d want 1", ale_n); end
    n_cmp++; if (ale_t != 1) begin n_bad++; $display("FAIL sw_ale_latency: got %0d want 1", ale_t); end
    n_cmp++; if (ale_addr !== 8'h10) begin n_bad++; $display("FAIL sw_ale_addr: got %h want 10", ale_addr); end
    n_cmp++; if (ale_data !== 8'hA5) begin n_bad++; $display("FAIL sw_ale_data: got %h want a5", ale_data); end
    n_cmp++; if (wr_n != 2) begin n_bad++; $display("FAIL sw_write_cycles: got %0d want 2", wr_n); end
    n_cmp++; if (rd_n != 0) begin n_bad++; $display("FAIL sw_read_cycles: got %0d want 0", rd_n); end
    n_cmp++; if (first_rsp != 5) begin n_bad++; $display("FAIL sw_rsp_latency: got %0d want 5", first_rsp); end
    n_cmp++; if (rsp_word !== 9'h000) begin n_bad++; $display("FAIL sw_rsp_word: got %h want 000", rsp_word); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL sw_rsp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL sw_rsp: got %h want %h", g, e); end
    end
  endtask

  task automatic test_read_back();
    bit ok1, ok2;
    logic [8:0] e, g;
    int idx = 0;
    rsp_ready = 1'b1;
    push_req(1'b1, 8'h10, 8'hA5, 8, ok1);
    push_req(1'b0, 8'h10, 8'h00, 8, ok2);
    n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_bad++; $display("FAIL rb_accept: got %b want 11", {ok1, ok2}); end
    drain(60);
    n_cmp++; if (got_q.size() != 2 || exp_q.size() != 2) begin n_bad++; $display("FAIL rb_rsp_count: got %0d want 2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rb_rsp%0d: got %h want %h", idx, g, e); end
      if (idx == 1) begin
        n_cmp++; if (g !== 9'h0A5) begin n_bad++; $display("FAIL rb_readback: got %h want 0a5", g); end
      end
      idx++;
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int acc = 0;
    logic [8:0] e, g;
    rsp_ready = 1'b0; bus_lat = 3;
    for (int i = 0; i < 6; i++) begin
      push_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 8, ok);
      if (ok) acc++;
    end
    n_cmp++; if (acc != 5) begin n_bad++; $display("FAIL ff_accepted: got %0d want 5", acc); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ff_count: got %0d want 4", fifo_count); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ff_ready: got %b want 0", req_ready); end
    rsp_ready = 1'b1;
    drain(200);
    n_cmp++; if (got_q.size() != 5 || exp_q.size() != 5) begin n_bad++; $display("FAIL ff_rsp_count: got %0d want 5", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ff_rsp: got %h want %h", g, e); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [8:0] hold, e, g;
    rsp_ready = 1'b0; bus_lat = 2;
    push_req(1'b0, 8'h10, 8'h00, 8, ok);
    for (int i = 0; i < 30 && !rsp_valid; i++) tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
    hold = {rsp_err, rsp_rdata};
    n_cmp++; if (exp_q.size() == 0 || hold !== exp_q[0]) begin n_bad++; $display("FAIL bp_rsp_data: got %h want %h", hold, exp_q.size() ? exp_q[0] : 9'h1FF); end
    push_req(1'b1, 8'h20, 8'($urandom), 8, ok);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, hold}) begin n_bad++; $display("FAIL bp_hold%0d: got %h want %h", i, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, hold}); end
      n_cmp++; if (ale_en !== 1'b0) begin n_bad++; $display("FAIL bp_no_ale%0d: got %b want 0", i, ale_en); end
    end
    rsp_ready = 1'b1;
    drain(60);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_rsp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL bp_rsp: got %h want %h", g, e); end
    end
  endtask

  task automatic test_random();
    logic [8:0] e, g;
    int n = 0;
    for (int i = 0; i < 80; i++) begin
      bus_lat = $urandom_range(2, 5);
      rsp_ready = ($urandom_range(0, 9) < 7);
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 15));
      req_wdata = 8'($urandom);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    drain(400);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_rsp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rnd_rsp%0d: got %h want %h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bus_stall = 1'b1; rsp_ready = 1'b1; bus_lat = 2;
    push_req(1'b0, 8'h03, 8'h00, 8, ok);
`ifdef BUS_TIMEOUT_EN
    begin
      int dly = -1;
      logic [8:0] word = '0, g;
      for (int i = 0; i < 10 && !ale_en; i++) tick();
      for (int t = 1; t <= 40 && dly < 0; t++) begin
        tick();
        if (rsp_valid) begin dly = t; word = {rsp_err, rsp_rdata}; end
      end
      bus_stall = 1'b0;
      n_cmp++; if (dly != 17) begin n_bad++; $display("FAIL to_latency: got %0d want 17", dly); end
      n_cmp++; if (word !== 9'h100) begin n_bad++; $display("FAIL to_rsp_word: got %h want 100", word); end
      drain(60);
      n_cmp++; if (got_q.size() != 1 || exp_q.size() != 1) begin n_bad++; $display("FAIL to_rsp_count: got %0d want 1", got_q.size()); end
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        n_cmp++; if (g !== 9'h100) begin n_bad++; $display("FAIL to_rsp: got %h want 100", g); end
      end
      clear_model();
    end
`else
    begin
      int hi = 0;
      for (int t = 0; t < 40; t++) begin
        tick();
        if (rsp_valid) hi++;
      end
      n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL to_no_rsp: got %0d want 0", hi); end
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    logic [8:0] e, g;
    int pre_exp;
`ifdef BUS_TIMEOUT_EN
    pre_exp = 2;
`else
    pre_exp = 3;
`endif
    bus_stall = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_req(1'b0, 8'($urandom_range(0, 15)), 8'h00, 8, ok);
    repeat (6) tick();
    n_cmp++; if (int'(fifo_count) != pre_exp) begin n_bad++; $display("FAIL rw_pre_count: got %0d want %0d", fifo_count, pre_exp); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({ale_en, bus_read_en, bus_write_en, rsp_valid} !== 4'b0000) begin n_bad++; $display("FAIL rw_outputs: got %b want 0000", {ale_en, bus_read_en, bus_write_en, rsp_valid}); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rw_count: got %0d want 0", fifo_count); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rw_ready: got %b want 1", req_ready); end
    clear_model();
    ale_prev = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus_stall = 1'b0; bus_lat = 2;
    @(negedge clk);
    push_req(1'b1, 8'h44, 8'h5C, 8, ok);
    push_req(1'b0, 8'h44, 8'h00, 8, ok);
    drain(60);
    n_cmp++; if (got_q.size() != 2 || exp_q.size() != 2) begin n_bad++; $display("FAIL rw_recover_count: got %0d want 2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rw_recover: got %h want %h", g, e); end
    end
  endtask

  task automatic test_strobe_rules();
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL both_strobes: got %0d want 0", both_cnt); end
    n_cmp++; if (ale_dbl != 0) begin n_bad++; $display("FAIL ale_back_to_back: got %0d want 0", ale_dbl); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_fifo_full();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_in_wait();
    test_strobe_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_req_seq.md
Name: bus_req_seq

Overview:
- Bus-master request sequencer sitting directly upstream of the 256-byte system bus (SYS_BUS_TEST).
- Accepts read/write requests from a core-side valid/ready interface and buffers them in a small command FIFO.
- Converts each request into the bus's ALE → command → completion handshake, then returns read data or a write acknowledgement on a valid/ready response interface.

Parameters:
- ADDR_W, 8, bus address width; matches bus MEM_DEPTH.
- DATA_W, 8, bus data width; matches bus MEM_WIDTH.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TIMEOUT, 15, maximum WAIT cycles before an error response; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted this cycle; equals FIFO not full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  transaction timed out.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- bus_ready  in  1  bus idle/complete indicator.
- ale_en  out  1  address latch enable to the bus.
- bus_read_en  out  1  read strobe.
- bus_write_en  out  1  write strobe.
- addr_input  out  ADDR_W  address to the bus.
- data_write  out  DATA_W  write data to the bus.
- data_read  in  DATA_W  read data from the bus; valid when bus_ready=1 after a read.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE and the FIFO empties.
  - All outputs clear to 0; req_ready=1 follows.
  - Bus strobes drop immediately, including mid-transaction; the in-flight request is lost and no response is issued.
- FIFO:
  - Push when req_valid && req_ready.
  - Pop on the IDLE→ALE transition; the head entry latches into working registers cur_write, cur_addr and cur_wdata.
  - req_ready = (count != FIFO_DEPTH), so no push occurs when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ALE, CMD, WAIT, RESP.
  - IDLE: all strobes 0. Go to ALE when count > 0 and bus_ready = 1.
  - ALE (1 cycle):
    - ale_en = 1; addr_input = cur_addr; data_write = cur_wdata.
    - bus_read_en = !cur_write; bus_write_en = cur_write.
    - Always go to CMD.
  - CMD (1 cycle): ale_en = 0; the selected strobe, address and data stay held. Always go to WAIT.
  - WAIT:
    - Strobes are 0; addr_input and data_write keep their values.
    - When bus_ready = 1: capture rsp_rdata = cur_write ? 0 : data_read, set rsp_err = 0, go to RESP.
  - RESP:
    - rsp_valid = 1, with rsp_rdata and rsp_err held stable.
    - On rsp_ready: go to IDLE and drop rsp_valid in the next cycle.
- Only one transaction is in flight at a time. Exactly one of bus_read_en or bus_write_en is set per transaction, so the bus never sees both strobes set together.
- Latency with no back-pressure: request accepted at edge N → ALE at N+1 → rsp_valid at N+5 at the earliest (bus completes 2 cycles after CMD).
- Back-to-back operation: IDLE needs 1 cycle after RESP, so ale_en never stays high across transactions.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle with bus_ready = 0.
  - When it reaches TIMEOUT: go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - If bus_ready = 1 in the same cycle the counter reaches TIMEOUT, completion wins (rsp_err = 0).
- Undefined: no counter is built, WAIT waits indefinitely, and rsp_err is tied to 0.

Test Plan:
- Single write: push write addr 0x10, data 0xA5 against a bus model. Expect ale_en high for 1 cycle with addr_input = 0x10, bus_write_en high for 2 cycles, then rsp_valid with rsp_err = 0 and rsp_rdata = 0x00.
- Read-back: push write 0x10/0xA5, then read 0x10. Expect the second response rsp_rdata = 0xA5, and responses in order.
- FIFO full: hold rsp_ready = 0 and push 6 requests. Expect req_ready = 0 once fifo_count = 4 with no loss. Then release rsp_ready and expect all accepted requests answered in order.
- Response back-pressure: hold rsp_ready = 0 for 10 cycles in RESP. Expect rsp_valid, rsp_rdata and rsp_err stable, and no new ale_en pulse.
- Timeout (BUS_TIMEOUT_EN): bus model holds bus_ready = 0 after ALE. Expect rsp_err = 1 and rsp_rdata = 0 after 15 WAIT cycles. Without the macro, rsp_valid never rises.
- Async reset in WAIT: assert rst = 0 mid-transaction. Expect ale_en, bus_read_en, bus_write_en and rsp_valid all 0 immediately, fifo_count = 0 and req_ready = 1.
